// File: rtl/icff_reader.sv
// icff_reader: drains the inter-core FIFO through a 2-entry skid buffer
// and frames header/payload messages into a valid/ready stream.
module icff_reader #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ff_do,
  input  logic             ff_empty,
  output logic             ff_re,
  output logic [15:0]      m_dat,
  output logic             m_vld,
  input  logic             m_rdy,
  output logic             m_sop,
  output logic             m_eop,
  output logic [7:0]       m_id,
  output logic [CNT_W-1:0] msg_cnt,
  output logic             busy
);

  typedef enum logic {
    HDR = 1'b0,
    PAY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [15:0]      r_buf0;
  logic [15:0]      r_buf1;
  logic [1:0]       r_occ;
  logic             r_infl;
  logic [7:0]       r_rem;
  logic             r_first;
  logic [7:0]       r_id;
  logic [CNT_W-1:0] r_cnt;

  logic             w_hdr_take;
  logic             w_xfer;
  logic             w_pop;
  logic [2:0]       w_lvl;
  logic [2:0]       w_occ_n;
  logic [1:0]       w_wr_idx;
  logic [7:0]       w_len;

  assign w_len      = r_buf0[7:0];
  assign w_hdr_take = (r_state == HDR) && (r_occ != 2'd0);
  assign m_vld      = (r_state == PAY) && (r_occ != 2'd0);
  assign w_xfer     = m_vld && m_rdy;
  assign w_pop      = w_hdr_take || w_xfer;

  // Level after this cycle's pending write and pop settle.
  assign w_lvl   = {1'b0, r_occ} + {2'b00, r_infl};
  assign w_occ_n = w_lvl - {2'b00, w_pop};
  assign w_wr_idx = r_occ - {1'b0, w_pop};

  assign ff_re = !rst && !ff_empty &&
                 (w_lvl <= 3'd1 + {2'b00, w_pop});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_occ  <= 2'd0;
      r_infl <= 1'b0;
    end else begin
      r_occ  <= w_occ_n[1:0];
      r_infl <= ff_re;
      if (w_pop) begin
        r_buf0 <= r_buf1;
      end
      if (r_infl) begin
        if (w_wr_idx == 2'd0) begin
          r_buf0 <= ff_do;
        end else begin
          r_buf1 <= ff_do;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HDR;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      HDR: begin
        if (w_hdr_take && (w_len != 8'd0)) begin
          w_state_n = PAY;
        end
      end
      PAY: begin
        if (w_xfer && (r_rem == 8'd1)) begin
          w_state_n = HDR;
        end
      end
      default: w_state_n = HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem   <= 8'd0;
      r_first <= 1'b0;
      r_id    <= 8'd0;
      r_cnt   <= '0;
    end else if (w_hdr_take) begin
      r_id <= r_buf0[15:8];
      if (w_len == 8'd0) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_rem   <= w_len;
        r_first <= 1'b1;
      end
    end else if (w_xfer) begin
      r_rem   <= r_rem - 8'd1;
      r_first <= 1'b0;
      if (r_rem == 8'd1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign m_dat   = r_buf0;
  assign m_sop   = (r_state == PAY) && r_first;
  assign m_eop   = (r_state == PAY) && (r_rem == 8'd1);
  assign m_id    = r_id;
  assign msg_cnt = r_cnt;
  assign busy    = (r_state == PAY);

`ifndef SYNTHESIS
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst) w_occ_n <= 3'd2
  );
`endif

endmodule

// File: tb/tb_icff_reader.sv
// tb_icff_reader: directed bench with a behavioural FIFO, stream
// monitor and occupancy model for icff_reader.
module tb_icff_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ff_do = '0;
  logic        ff_empty;
  logic        ff_re;
  logic [15:0] m_dat;
  logic        m_vld;
  logic        m_rdy = 1'b0;
  logic        m_sop;
  logic        m_eop;
  logic [7:0]  m_id;
  logic [3:0]  msg_cnt;
  logic        busy;

  icff_reader #(.CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ff_do    (ff_do),
    .ff_empty (ff_empty),
    .ff_re    (ff_re),
    .m_dat    (m_dat),
    .m_vld    (m_vld),
    .m_rdy    (m_rdy),
    .m_sop    (m_sop),
    .m_eop    (m_eop),
    .m_id     (m_id),
    .msg_cnt  (msg_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural FIFO with one-cycle read latency
  logic [15:0] mem [0:1023];
  int          wp = 0;
  int          rp = 0;
  bit          clr_with_rst = 1'b0;

  assign ff_empty = (wp == rp);

  always @(posedge clk) begin
    if (rst && clr_with_rst) begin
      rp <= wp;
    end else if (ff_re && !ff_empty) begin
      ff_do <= mem[rp % 1024];
      rp    <= rp + 1;
    end
  end

  task automatic push(input logic [15:0] w);
    mem[wp % 1024] = w;
    wp++;
  endtask

  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_rdy = 1'b1;
      1:       m_rdy = ($urandom_range(0, 99) < 30);
      default: m_rdy = 1'b0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] d;
    logic        s;
    logic        e;
    logic [7:0]  id;
    int          c;
  } rx_t;

  rx_t rx[$];
  rx_t rx_tmp;

  int          tb_occ = 0;
  bit          tb_infl = 1'b0;
  bit          tb_pop;
  int          tb_lvl;
  int          ffre_viol = 0;
  int          vld_viol = 0;
  int          stall_viol = 0;
  int          starve_viol = 0;
  bit          starve_chk = 1'b0;
  bit          p_stall = 1'b0;
  logic [15:0] p_dat;
  logic        p_sop;
  logic        p_eop;
  logic [7:0]  p_id;

  always @(negedge clk) begin
    if (rst) begin
      tb_occ  = 0;
      tb_infl = 1'b0;
      p_stall = 1'b0;
    end else begin
      tb_pop = (tb_occ != 0) && (!busy || m_rdy);
      tb_lvl = tb_occ + int'(tb_infl) - int'(tb_pop);
      if (ff_re && tb_lvl > 1) ffre_viol++;
      if (tb_lvl > 2) ffre_viol++;
      if (m_vld !== (busy && tb_occ != 0)) vld_viol++;
      if (p_stall && (m_dat !== p_dat || m_sop !== p_sop ||
                      m_eop !== p_eop || m_id !== p_id))
        stall_viol++;
      if (starve_chk && (m_vld || !busy)) starve_viol++;
      if (m_vld && m_rdy) begin
        rx_tmp.d  = m_dat;
        rx_tmp.s  = m_sop;
        rx_tmp.e  = m_eop;
        rx_tmp.id = m_id;
        rx_tmp.c  = cyc;
        rx.push_back(rx_tmp);
      end
      p_stall = m_vld && !m_rdy;
      p_dat   = m_dat;
      p_sop   = m_sop;
      p_eop   = m_eop;
      p_id    = m_id;
      tb_occ  = tb_lvl;
      tb_infl = ff_re;
    end
  end

  task automatic wait_cnt(input string tag, input logic [3:0] tgt,
                          input int lim);
    int n = 0;
    while (msg_cnt !== tgt && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(msg_cnt), 32'(tgt));
  endtask

  task automatic wait_rx(input string tag, input int tgt, input int lim);
    int n = 0;
    while (rx.size() < tgt && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, rx.size(), tgt);
  endtask

  logic [15:0] exp_q[$];
  int          e;

  initial begin
    // Reset held while the FIFO already has a message queued
    push(16'h2A03);
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    repeat (3) @(negedge clk);
    chk("rst_ff_re", 32'(ff_re), 0);
    chk("rst_m_vld", 32'(m_vld), 0);
    chk("rst_msg_cnt", 32'(msg_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_m_dat", 32'(m_dat), 0);
    @(posedge clk) #1 rst = 1'b0;

    // Single message at full rate
    wait_cnt("t2_cnt", 4'd1, 50);
    @(negedge clk);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_nrx", rx.size(), 3);
    if (rx.size() == 3) begin
      chk("t2_d0", 32'(rx[0].d), 32'h1111);
      chk("t2_d1", 32'(rx[1].d), 32'h2222);
      chk("t2_d2", 32'(rx[2].d), 32'h3333);
      chk("t2_sop", {29'd0, rx[0].s, rx[1].s, rx[2].s}, 32'b100);
      chk("t2_eop", {29'd0, rx[0].e, rx[1].e, rx[2].e}, 32'b001);
      chk("t2_id", 32'(rx[0].id), 32'h2A);
      chk("t2_consec", rx[2].c - rx[0].c, 2);
    end
    rx.delete();

    // Zero-length message followed by a one-word message
    push(16'h0500);
    push(16'h0601);
    push(16'hBEEF);
    wait_cnt("t3_cnt1", 4'd2, 50);
    chk("t3_nrx_mid", rx.size(), 0);
    wait_cnt("t3_cnt2", 4'd3, 50);
    @(negedge clk);
    chk("t3_nrx", rx.size(), 1);
    if (rx.size() == 1) begin
      chk("t3_dat", 32'(rx[0].d), 32'hBEEF);
      chk("t3_sop_eop", {30'd0, rx[0].s, rx[0].e}, 32'b11);
      chk("t3_id", 32'(rx[0].id), 32'h06);
    end
    rx.delete();

    // 255-word message under random back-pressure
    push(16'h7FFF);
    for (int i = 0; i < 255; i++) begin
      exp_q.push_back(16'(i * 16'h0137) ^ 16'h5A00);
      push(exp_q[i]);
    end
    rdy_mode = 1;
    wait_cnt("t4_cnt", 4'd4, 5000);
    rdy_mode = 0;
    @(negedge clk);
    chk("t4_nrx", rx.size(), 255);
    e = 0;
    for (int i = 0; i < rx.size() && i < 255; i++) begin
      if (rx[i].d !== exp_q[i]) e++;
      if (rx[i].s !== (i == 0)) e++;
      if (rx[i].e !== (i == 254)) e++;
      if (rx[i].id !== 8'h7F) e++;
    end
    chk("t4_stream", e, 0);
    chk("t4_ffre_rule", ffre_viol, 0);
    chk("t4_vld_model", vld_viol, 0);
    chk("t4_stall_hold", stall_viol, 0);
    rx.delete();
    exp_q.delete();

    // Starvation mid-message
    push(16'h3305);
    push(16'hA001);
    push(16'hA002);
    wait_rx("t5_rx2", 2, 50);
    @(posedge clk) #1 starve_chk = 1'b1;
    repeat (10) @(posedge clk);
    #1 starve_chk = 1'b0;
    chk("t5_starve", starve_viol, 0);
    push(16'hA003);
    push(16'hA004);
    push(16'hA005);
    wait_cnt("t5_cnt", 4'd5, 50);
    @(negedge clk);
    chk("t5_nrx", rx.size(), 5);
    if (rx.size() == 5) begin
      e = 0;
      for (int i = 0; i < 5; i++) begin
        if (rx[i].d !== 16'hA001 + 16'(i)) e++;
        if (rx[i].e !== (i == 4)) e++;
        if (rx[i].id !== 8'h33) e++;
      end
      chk("t5_stream", e, 0);
    end
    rx.delete();

    // Asynchronous reset in the middle of a message
    clr_with_rst = 1'b1;
    push(16'h4405);
    for (int i = 1; i <= 5; i++) push(16'hB000 + 16'(i));
    wait_rx("t6_rx", 2, 50);
    @(posedge clk) #1 rdy_mode = 2;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_ff_re", 32'(ff_re), 0);
    chk("t6_m_vld", 32'(m_vld), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_msg_cnt", 32'(msg_cnt), 0);
    chk("t6_sop_eop", {30'd0, m_sop, m_eop}, 0);
    chk("t6_m_dat", 32'(m_dat), 0);
    @(posedge clk) #1 rst = 1'b0;
    rdy_mode = 0;
    repeat (5) @(negedge clk);
    chk("t6_hdr", 32'(busy), 0);
    chk("t6_cnt_after", 32'(msg_cnt), 0);
    chk("t6_first", 32'(rx[0].d), 32'hB001);
    rx.delete();
    clr_with_rst = 1'b0;

    // 17 messages through a 4-bit counter
    for (int k = 0; k < 17; k++) begin
      push({8'(k), 8'h01});
      push(16'hC000 + 16'(k));
    end
    wait_rx("t7_rx", 17, 400);
    repeat (3) @(negedge clk);
    chk("t7_wrap", 32'(msg_cnt), 1);
    if (rx.size() == 17) begin
      chk("t7_last_dat", 32'(rx[16].d), 32'hC010);
      chk("t7_last_id", 32'(rx[16].id), 32'h10);
    end
    chk("t7_ffre_rule", ffre_viol, 0);
    chk("t7_vld_model", vld_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/icff_reader.md
# icff_reader

Read-side controller for the 16-bit inter-core FIFO. It drains words from the FIFO read port, which has a one-cycle read latency and no output register. It parses them into messages: one header word followed by 0–255 payload words. Payload words go to the consuming core as a valid/ready stream with start/end markers. It sits between the FIFO read port and the receiving core's bus-side message interface.

## Interface
- CNT_W, 16, width of the completed-message counter `msg_cnt`; wraps modulo 2^CNT_W.
- clk  in  1  single system clock; all logic is rising-edge.
- rst  in  1  asynchronous reset, active-high.
- ff_do  in  16  FIFO read data; valid the cycle after an accepted `ff_re`.
- ff_empty  in  1  FIFO empty flag.
- ff_re  out  1  FIFO read enable.
- m_dat  out  16  payload word at buffer head.
- m_vld  out  1  payload word valid.
- m_rdy  in  1  consumer ready; a transfer occurs when `m_vld & m_rdy`.
- m_sop  out  1  first payload word of a message; qualified by `m_vld`.
- m_eop  out  1  last payload word of a message; qualified by `m_vld`.
- m_id  out  8  destination id of the current message (header[15:8]).
- msg_cnt  out  CNT_W  count of completed messages.
- busy  out  1  high in PAY state.

Reset is asynchronous and active-high on `rst`, with the single clock `clk`. No other clock or reset exists.

## Operation
**Prefetch**
- A 2-entry FIFO-order skid buffer holds data words. The occupancy counter `occ` is 0..2.
- A 1-bit `infl` flag marks a read issued last cycle.
- `pop` = payload transfer OR header consume in the current cycle.
- `ff_re = !ff_empty && (occ + infl - pop) <= 1`. This path is combinational from `m_rdy` and is accepted.
- When `infl` is set, `ff_do` is written into the buffer tail this cycle.
- The buffer never overflows. Overflow is an assertion failure.

**Framing FSM**
- Two states: HDR (reset state) and PAY.
- Header word format: [15:8] = id, [7:0] = len.
- HDR, buffer non-empty:
  - Consume the head word (pop, no `m_vld`).
  - Latch `m_id` <= id.
  - If len == 0: increment `msg_cnt` and stay in HDR.
  - Otherwise: `rem` <= len, `first` <= 1, go to PAY.
- PAY:
  - `m_vld` = (occ != 0), `m_dat` = head word.
  - `m_sop` = `first`, `m_eop` = (rem == 1).
  - On each transfer: `rem` decrements and `first` clears.
  - On the transfer with rem == 1: increment `msg_cnt` and go to HDR.
- In HDR, `m_vld` = 0 regardless of occupancy. Words in HDR are always interpreted as headers.
- `m_dat`, `m_id`, `m_sop` and `m_eop` hold their values while `m_vld & !m_rdy` (stall). The consumer may drop `m_rdy` at any time.
- `msg_cnt` wraps from all-ones to 0 without saturation.

**Reset**
- `rst` asserted clears: `occ`, `infl`, `rem`, `first`, `m_id`=0, `msg_cnt`=0, state=HDR.
- All outputs go low/zero immediately: `ff_re`=0, `m_vld`=0, `m_sop`=0, `m_eop`=0, `busy`=0, `m_dat`=0.
- A partially delivered message is discarded. If the FIFO still holds that message's tail, it is misframed; software must reset the FIFO together with this block. The FIFO's own `rst` is driven from the same net.

## Timing
- FIFO latency: `ff_re` at cycle t → word in buffer at the t+1 edge → visible as head at t+2 if the buffer was empty.
- Header overhead: one cycle per message. The header is consumed in the cycle it is at the buffer head.
- First payload word of a message: `m_vld` rises the cycle after header consume, if the word is already buffered.
- Sustained throughput: with `m_rdy`=1 and the FIFO non-empty, one payload word per cycle. Between messages there is one bubble cycle (the header).
- Empty FIFO mid-message: `m_vld` drops once the buffer drains and recovers 2 cycles after `ff_empty` falls.
- Simultaneous write and pop in the same cycle: `occ` is unchanged and the head advances.

## Test plan
- **Reset values:** hold `rst` with FIFO non-empty → `ff_re`=0, `m_vld`=0, `msg_cnt`=0, `busy`=0; async assert mid-cycle clears the outputs before the next edge.
- **Single message at full rate:** FIFO holds 0x2A03, 0x1111, 0x2222, 0x3333, `m_rdy`=1 → `m_id`=0x2A; 3 transfers on consecutive cycles; `m_sop` on 0x1111; `m_eop` on 0x3333; `msg_cnt`=1; `busy` falls after the last transfer.
- **Zero-length then normal:** headers 0x0500, 0x0601, payload 0xBEEF → no `m_vld` for the first message; `msg_cnt`=1 then 2; `m_id`=0x06 with 0xBEEF carrying both `m_sop` and `m_eop`.
- **Back-pressure:** 255-word message, `m_rdy` random 30% → the stream matches the FIFO contents in order; no word lost or duplicated; `ff_re` never asserted when `occ + infl - pop` > 1; `m_dat` stable during stalls.
- **Starvation:** deassert writes mid-message for 10 cycles → `m_vld` low while the buffer is empty, `busy` stays 1; resume and the message completes with the correct `m_eop`.
- **Reset mid-message and counter wrap:** assert `rst` at payload word 2 of 5 → state HDR, `msg_cnt`=0. Separately, with CNT_W=4, send 17 messages → `msg_cnt` = 1.
